sdp_ram_be: RTL

- Single-clock simple dual-port RAM: one write port (A) and one read port (B).
- Generalises the team's two-clock RAM with:
  - byte-lane write enables
  - a selectable read-during-write collision mode
  - an optional output pipeline register
  - a read-valid strobe
  - a reset-triggered hardware clear engine that zeroes the array.
- Used as the storage primitive under FIFOs and lookup tables where deterministic power-up contents matter.

---
 rtl/sdp_ram_pkg.sv | 13 +
 rtl/sdp_ram_array.sv | 39 +++
 rtl/sdp_ram_be.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared definitions for the byte-enabled simple dual-port RAM.
package sdp_ram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  function automatic int lanes(input int dataWidth, input int byteWidth);
    return dataWidth / byteWidth;
  endfunction

endpackage

// File: rtl/sdp_ram_array.sv
// Storage only: byte-lane masked write port and a read-first registered read port.
module sdp_ram_array
  import sdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDRS_WIDTH = 4,
  parameter int BYTE_WIDTH  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wrEn,
  input  logic [ADDRS_WIDTH-1:0]                  wrAddrs,
  input  logic [DATA_WIDTH-1:0]                   wrData,
  input  logic [lanes(DATA_WIDTH, BYTE_WIDTH)-1:0] wrBe,
  input  logic                                    rdEn,
  input  logic [ADDRS_WIDTH-1:0]                  rdAddrs,
  output logic [DATA_WIDTH-1:0]                   rdData
);

  localparam int LANES = lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 2 ** ADDRS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < LANES; i++) begin
        if (wrBe[i]) mem[wrAddrs][i*BYTE_WIDTH +: BYTE_WIDTH] <= wrData[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Only the read register is reset, so a reset also zeroes the visible output.
  always_ff @(posedge clk) begin
    if (rst)       rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddrs];
  end

endmodule

// File: rtl/sdp_ram_be.sv
// Single-clock SDP RAM with byte enables, collision mode, optional output stage
// and a reset-triggered clear engine.
//   state    | meaning
//   ST_CLEAR | writing CLEAR_VALUE to address cnt each cycle, user traffic ignored
//   ST_IDLE  | ready, user reads and writes accepted
module sdp_ram_be
  import sdp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDRS_WIDTH    = 4,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    RD_MODE        = RD_FIRST,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DATA_WIDTH-1:0]                   dataA,
  input  logic [ADDRS_WIDTH-1:0]                  addrsA,
  input  logic                                    wrnA,
  input  logic [lanes(DATA_WIDTH, BYTE_WIDTH)-1:0] beA,
  input  logic [ADDRS_WIDTH-1:0]                  addrsB,
  input  logic                                    rdnB,
  output logic [DATA_WIDTH-1:0]                   dataB,
  output logic                                    validB,
  output logic                                    ready
);

  localparam int                     LANES      = lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDRS_WIDTH-1:0] LAST_ADDRS = '1;

  state_t                  state, stateNext;
  logic [ADDRS_WIDTH-1:0]  cnt;
  logic                    clearing;
  logic                    wrFire, rdFire;
  logic                    memWrEn;
  logic [ADDRS_WIDTH-1:0]  memAddrs;
  logic [DATA_WIDTH-1:0]   memData;
  logic [LANES-1:0]        memBe;
  logic [DATA_WIDTH-1:0]   rdData;
  logic                    colHitQ;
  logic [DATA_WIDTH-1:0]   colDataQ;
  logic [LANES-1:0]        colBeQ;
  logic                    validQ1;
  logic [DATA_WIDTH-1:0]   stage1Data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= stateNext;
      ready <= (stateNext == ST_IDLE);
      if (state == ST_CLEAR) cnt <= cnt + ADDRS_WIDTH'(1);
    end
  end

  always_comb begin
    stateNext = state;
    clearing  = 1'b0;
    case (state)
      ST_CLEAR: begin
        clearing = 1'b1;
        if (cnt == LAST_ADDRS) stateNext = ST_IDLE;
      end
      ST_IDLE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // ready is only high in ST_IDLE, so user traffic never competes with the clear.
  assign wrFire   = ready & wrnA & (|beA) & ~rst;
  assign rdFire   = ready & rdnB & ~rst;
  assign memWrEn  = (clearing & ~rst) | wrFire;
  assign memAddrs = clearing ? cnt : addrsA;
  assign memData  = clearing ? CLEAR_VALUE : dataA;
  assign memBe    = clearing ? '1 : beA;

  sdp_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDRS_WIDTH(ADDRS_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) uArray (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (memWrEn),
    .wrAddrs(memAddrs),
    .wrData (memData),
    .wrBe   (memBe),
    .rdEn   (rdFire),
    .rdAddrs(addrsB),
    .rdData (rdData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ1  <= 1'b0;
      colHitQ  <= 1'b0;
      colDataQ <= '0;
      colBeQ   <= '0;
    end else begin
      validQ1 <= rdFire;
      if (rdFire) begin
        colHitQ  <= (RD_MODE == WR_FIRST) && wrFire && (addrsA == addrsB);
        colDataQ <= dataA;
        colBeQ   <= beA;
      end
    end
  end

  // Write-first bypass: overlay the lanes written in the read cycle onto the old word.
  always_comb begin
    stage1Data = rdData;
    if (colHitQ) begin
      for (int i = 0; i < LANES; i++) begin
        if (colBeQ[i]) stage1Data[i*BYTE_WIDTH +: BYTE_WIDTH] = colDataQ[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  if (OUT_REG != 0) begin : gOutReg
    logic [DATA_WIDTH-1:0] dataQ2;
    logic                  validQ2;

    always_ff @(posedge clk) begin
      if (rst) begin
        dataQ2  <= '0;
        validQ2 <= 1'b0;
      end else begin
        validQ2 <= validQ1;
        if (validQ1) dataQ2 <= stage1Data;
      end
    end

    assign dataB  = dataQ2;
    assign validB = validQ2;
  end else begin : gNoOutReg
    assign dataB  = stage1Data;
    assign validB = validQ1;
  end

endmodule
